seq_checker: RTL and testbench

Synthesizable, cycle-accurate checker for the temporal property `a ##1 b ##1 c ##2 d`, evaluated on every enabled `clk` edge. It sits directly downstream of the a/b/c/d stimulus or design signals and is the hardware counterpart of the simulation assertion. A new attempt starts on every enabled cycle, and attempts overlap. The block counts passes and pushes per-cycle failure records into a FIFO, which a debug/CSR reader drains over a valid/ready interface.

---
 rtl/seq_chk_pkg.sv | 26 ++
 rtl/seq_checker_fifo.sv | 58 +++++
 rtl/seq_checker.sv | 121 ++++++++++++
 tb/tb_seq_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the a ##1 b ##1 c ##2 d checker.
// Record layout, attempt offsets and mask bit positions live here.
package seq_chk_pkg;

    localparam int REC_TS_W = 16;

    typedef struct packed {
        logic [REC_TS_W-1:0] ts;
        logic [3:0]          mask;
    } fail_rec_t;

    localparam int OFF_A = 0;
    localparam int OFF_B = 1;
    localparam int OFF_C = 2;
    localparam int OFF_D = 4;

    localparam int MB_A = 0;
    localparam int MB_B = 1;
    localparam int MB_C = 2;
    localparam int MB_D = 3;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/seq_checker_fifo.sv
// Shift-register FIFO: entry 0 is the head, so the output is a flop.
// Accepts a push in the same cycle as a pop even when full.
module sync_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  cnt_q;
    logic [AW:0]  cnt_m;
    logic [AW-1:0] wr_idx;
    logic         do_pop;
    logic         do_push;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign cnt_m   = do_pop ? cnt_q - 1'b1 : cnt_q;
    assign wr_idx  = cnt_m[AW-1:0];
    assign dout    = mem_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_q[i] <= mem_q[i+1];
                end
            end
            if (do_push) begin
                mem_q[wr_idx] <= din;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/seq_checker.sv
// Hardware checker for a ##1 b ##1 c ##2 d with overlapping attempts.
// Counts passes/fails and queues per-cycle failure records.
module seq_checker
    import seq_chk_pkg::*;
#(
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            a,
    input  logic            b,
    input  logic            c,
    input  logic            d,
    output logic            fail_valid,
    input  logic            fail_ready,
    output logic [TS_W-1:0] fail_ts,
    output logic [3:0]      fail_mask,
    output logic            pass_pulse,
    output logic [TS_W-1:0] pass_cnt,
    output logic [TS_W-1:0] fail_cnt,
    output logic [TS_W-1:0] drop_cnt
);

    localparam int REC_W = TS_W + 4;
    localparam logic [TS_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0] ts_q;
    logic            s1_q, s2_q, s3_q, s4_q;
    logic [3:0]      mask;
    logic            pass;
    logic [2:0]      nfail;
    logic [TS_W:0]   fail_sum;

    logic             push_req, push, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [REC_W-1:0] rec_in, rec_out;

    logic            pass_q;
    logic [TS_W-1:0] pass_cnt_q, fail_cnt_q, drop_cnt_q;

    // Each bit is the attempt that fails on this sample, by start offset.
    always_comb begin
        mask       = '0;
        mask[MB_A] = !a;
        mask[MB_B] = s1_q && !b;
        mask[MB_C] = s2_q && !c;
        mask[MB_D] = s4_q && !d;
        pass       = s4_q && d;
    end

    assign nfail    = popcount4(mask);
    assign fail_sum = {1'b0, fail_cnt_q} + (TS_W+1)'(nfail);

    assign push_req = en && (mask != 4'b0000);
    assign pop      = fail_valid && fail_ready;
    assign drop     = push_req && fifo_full && !pop;
    assign push     = push_req && !drop;
    assign rec_in   = {ts_q, mask};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
            s4_q <= 1'b0;
        end else if (en) begin
            ts_q <= ts_q + 1'b1;
            s1_q <= a;
            s2_q <= s1_q && b;
            s3_q <= s2_q && c;
            s4_q <= s3_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pass_q <= en && pass;
            if (en && pass && pass_cnt_q != CNT_MAX) begin
                pass_cnt_q <= pass_cnt_q + 1'b1;
            end
            if (en) begin
                fail_cnt_q <= fail_sum[TS_W] ? CNT_MAX
                                             : fail_sum[TS_W-1:0];
            end
            if (drop && drop_cnt_q != CNT_MAX) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    sync_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (rec_in),
        .pop   (pop),
        .dout  (rec_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fail_valid = !fifo_empty;
    assign fail_ts    = rec_out[REC_W-1:4];
    assign fail_mask  = rec_out[3:0];
    assign pass_pulse = pass_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with hand-computed expectations.
module tb_seq_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic        fail_ready = 1'b0;
    logic        fail_valid;
    logic [15:0] fail_ts;
    logic [3:0]  fail_mask;
    logic        pass_pulse;
    logic [15:0] pass_cnt, fail_cnt, drop_cnt;

    int checks = 0;
    int failures = 0;

    seq_checker #(.TS_W(16), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .fail_valid (fail_valid),
        .fail_ready (fail_ready),
        .fail_ts    (fail_ts),
        .fail_mask  (fail_mask),
        .pass_pulse (pass_pulse),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic e, input logic ia, input logic ib,
                       input logic ic, input logic id);
        en = e; a = ia; b = ib; c = ic; d = id;
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] t,
                            input logic [3:0] m);
        chk({tag, ".valid"}, 32'(fail_valid), 32'd1);
        chk({tag, ".ts"}, 32'(fail_ts), 32'(t));
        chk({tag, ".mask"}, 32'(fail_mask), 32'(m));
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst.valid", 32'(fail_valid), 32'd0);
        chk("rst.ts", 32'(fail_ts), 32'd0);
        chk("rst.mask", 32'(fail_mask), 32'd0);
        chk("rst.pass", 32'(pass_pulse), 32'd0);
        chk("rst.pcnt", 32'(pass_cnt), 32'd0);
        chk("rst.fcnt", 32'(fail_cnt), 32'd0);
        chk("rst.dcnt", 32'(drop_cnt), 32'd0);

        // a=0 for three cycles, consumer always ready
        fail_ready = 1'b1;
        drv(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_head("t1.rec", 16'(i), 4'b0001);
        end
        drv(0, 0, 0, 0, 0);
        chk("t1.fcnt", 32'(fail_cnt), 32'd3);
        chk("t1.pcnt", 32'(pass_cnt), 32'd0);

        // Single matching pattern 1,1,1,x,1
        do_reset();
        fail_ready = 1'b1;
        drv(1, 1, 0, 0, 0);
        step();
        chk("t2.v0", 32'(fail_valid), 32'd0);
        drv(1, 0, 1, 0, 0);
        step();
        chk_head("t2.r1", 16'd1, 4'b0001);
        drv(1, 0, 0, 1, 0);
        step();
        drv(1, 0, 0, 0, 0);
        step();
        chk("t2.nopass", 32'(pass_pulse), 32'd0);
        drv(1, 0, 0, 0, 1);
        step();
        chk("t2.pass", 32'(pass_pulse), 32'd1);
        chk("t2.pcnt", 32'(pass_cnt), 32'd1);
        chk_head("t2.r4", 16'd4, 4'b0001);
        chk("t2.fcnt", 32'(fail_cnt), 32'd4);
        drv(1, 0, 0, 0, 0);
        step();
        chk("t2.pass_end", 32'(pass_pulse), 32'd0);
        chk("t2.pcnt2", 32'(pass_cnt), 32'd1);
        drv(0, 0, 0, 0, 0);

        // Overlapping failures at b and c in one cycle
        do_reset();
        fail_ready = 1'b1;
        drv(1, 1, 0, 0, 0);
        step();
        drv(1, 1, 1, 0, 0);
        step();
        chk("t3.v1", 32'(fail_valid), 32'd0);
        drv(1, 1, 0, 0, 0);
        step();
        chk_head("t3.r2", 16'd2, 4'b0110);
        chk("t3.fcnt", 32'(fail_cnt), 32'd2);
        drv(0, 0, 0, 0, 0);

        // Full FIFO drops records, then drains in order
        do_reset();
        fail_ready = 1'b0;
        drv(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step();
        drv(0, 0, 0, 0, 0);
        chk("t4.fcnt", 32'(fail_cnt), 32'd12);
        chk("t4.dcnt", 32'(drop_cnt), 32'd4);
        step();
        chk_head("t4.hold", 16'd0, 4'b0001);
        fail_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_head("t4.drain", 16'(i), 4'b0001);
            step();
        end
        chk("t4.empty", 32'(fail_valid), 32'd0);

        // Enable gap in the middle of a matching pattern
        do_reset();
        fail_ready = 1'b1;
        drv(1, 1, 0, 0, 0);
        step();
        drv(1, 0, 1, 0, 0);
        step();
        drv(0, 0, 0, 0, 0);
        step();
        chk("t5.gap_pass", 32'(pass_pulse), 32'd0);
        step();
        chk("t5.gap_valid", 32'(fail_valid), 32'd0);
        chk("t5.gap_fcnt", 32'(fail_cnt), 32'd1);
        drv(1, 0, 0, 1, 0);
        step();
        chk_head("t5.r2", 16'd2, 4'b0001);
        drv(1, 0, 0, 0, 0);
        step();
        chk("t5.nopass", 32'(pass_pulse), 32'd0);
        drv(1, 0, 0, 0, 1);
        step();
        chk("t5.pass", 32'(pass_pulse), 32'd1);
        chk("t5.pcnt", 32'(pass_cnt), 32'd1);
        chk_head("t5.r4", 16'd4, 4'b0001);
        drv(0, 0, 0, 0, 0);

        // Reset while s3 is live with two records queued
        do_reset();
        fail_ready = 1'b0;
        drv(1, 0, 0, 0, 0);
        step();
        step();
        drv(1, 1, 0, 0, 0);
        step();
        drv(1, 1, 1, 0, 0);
        step();
        drv(1, 1, 1, 1, 0);
        step();
        drv(0, 0, 0, 0, 0);
        chk("t6.pre_fcnt", 32'(fail_cnt), 32'd2);
        chk_head("t6.pre", 16'd0, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("t6.rst_valid", 32'(fail_valid), 32'd0);
        chk("t6.rst_fcnt", 32'(fail_cnt), 32'd0);
        chk("t6.rst_pass", 32'(pass_pulse), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("t6.idle_valid", 32'(fail_valid), 32'd0);
        chk("t6.idle_pcnt", 32'(pass_cnt), 32'd0);
        drv(1, 1, 0, 0, 0);
        step();
        chk("t6.e0_fcnt", 32'(fail_cnt), 32'd0);
        drv(1, 0, 0, 0, 0);
        step();
        chk_head("t6.ts1", 16'd1, 4'b0011);
        chk("t6.e1_fcnt", 32'(fail_cnt), 32'd2);
        chk("t6.e1_pass", 32'(pass_pulse), 32'd0);
        chk("t6.dcnt", 32'(drop_cnt), 32'd0);
        drv(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
